// File: rtl/sipo_collector.sv
// Serial-in parallel-out frame collector with a 2-entry valid/ready output buffer.
// Latency: a word is visible on data_out the edge its last bit is sampled (if the buffer was empty).
// Backpressure: a full buffer drops completed words (sticky overrun) unless a pop frees a slot on the same edge.
module sipo_collector #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             frame_start,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             aborted,
  input  logic             clr_flags
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt, next_cnt;
  // Only the WIDTH-1 most recent bits matter: the incoming bit completes the word.
  logic [WIDTH-2:0] sr, next_sr;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             set_abort;

  logic [WIDTH-1:0] mem [0:1];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             push, pop, drop;

  assign shifted = {sr, serial_in};

  // Frame state machine: next state, bit count, shift contents and word completion.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_sr    = sr;
    word_done  = 1'b0;
    set_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en && frame_start) begin
          next_sr    = shifted[WIDTH-2:0];
          next_cnt   = CW'(1);
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (sample_en) begin
          next_sr = shifted[WIDTH-2:0];
          if (frame_start) begin
            // Restart: the new bit becomes the MSB of a fresh frame.
            set_abort = 1'b1;
            next_cnt  = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            word_done  = 1'b1;
            next_cnt   = '0;
            next_state = IDLE;
          end else begin
            next_cnt = cnt + CW'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      sr    <= next_sr;
    end
  end

  assign pop  = data_valid && data_ready;
  // A pop on the same edge frees the slot the new word needs.
  assign push = word_done && ((count != 2'd2) || pop);
  assign drop = word_done && !push;

  // Output buffer storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Sticky status flags; a set event on the same edge beats clr_flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (drop)           overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (set_abort)      aborted <= 1'b1;
      else if (clr_flags) aborted <= 1'b0;
    end
  end

  assign data_valid = (count != 2'd0);
  assign data_out   = data_valid ? mem[rd_ptr] : '0;
  assign busy       = (state == SHIFT);

endmodule
